// File: rtl/hazard_control_unit_if.sv
// Hazard-control bundle between the 5-stage pipeline and the hazard unit.
// The pipeline side (master) reports register usage and stage status. The
// hazard unit side (slave) returns per-stage write enables, flushes,
// the watchdog error and the performance counters.
interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);
  // Pipeline status
  logic [4:0]       if_id_rs1_addr;
  logic [4:0]       if_id_rs2_addr;
  logic             if_id_rs1_used;
  logic             if_id_rs2_used;
  logic [4:0]       id_ex_rd_addr;
  logic             id_ex_mem_read_en;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  // Pipeline control
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_write_en;
  logic             id_ex_flush;
  logic             ex_mem_write_en;
  logic             mem_wb_flush;

  // Health and statistics
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output if_id_rs1_addr, if_id_rs2_addr, if_id_rs1_used, if_id_rs2_used,
           id_ex_rd_addr, id_ex_mem_read_en, ex_branch_taken, mem_req, mem_ready,
    input  pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush,
           ex_mem_write_en, mem_wb_flush, mem_timeout_err, stall_count, flush_count
  );

  modport slave (
    input  if_id_rs1_addr, if_id_rs2_addr, if_id_rs1_used, if_id_rs2_used,
           id_ex_rd_addr, id_ex_mem_read_en, ex_branch_taken, mem_req, mem_ready,
    output pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush,
           ex_mem_write_en, mem_wb_flush, mem_timeout_err, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage RV32I pipeline.
// Handles the hazards that forwarding cannot hide:
//   - multi-cycle data-memory accesses (freeze the front, bubble MEM/WB)
//   - taken branches (squash IF/ID and ID/EX)
//   - load-use dependencies (hold PC and IF/ID for one cycle, bubble ID/EX)
// Control outputs are purely combinational. The memory-stall watchdog and
// the saturating stall and flush counters are registered.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_control_unit_if.slave  hz
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic              w_mem_stall;
  logic              w_rs1_hit;
  logic              w_rs2_hit;
  logic              w_load_use;

  logic              w_pc_write_en;
  logic              w_if_id_write_en;
  logic              w_if_id_flush;
  logic              w_id_ex_write_en;
  logic              w_id_ex_flush;
  logic              w_ex_mem_write_en;
  logic              w_mem_wb_flush;

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout_err;
  logic [CNT_W-1:0]  r_stall_count;
  logic [CNT_W-1:0]  r_flush_count;

  // A load writing x0 never produces a real dependency, and an operand
  // the ID instruction does not read is never compared.
  assign w_mem_stall = hz.mem_req & ~hz.mem_ready;
  assign w_rs1_hit   = hz.if_id_rs1_used & (hz.id_ex_rd_addr == hz.if_id_rs1_addr);
  assign w_rs2_hit   = hz.if_id_rs2_used & (hz.id_ex_rd_addr == hz.if_id_rs2_addr);
  assign w_load_use  = hz.id_ex_mem_read_en & (hz.id_ex_rd_addr != 5'd0) &
                       (w_rs1_hit | w_rs2_hit);

  // Priority-ordered control decode: memory stall, then branch, then load-use.
  always_comb begin
    w_pc_write_en     = 1'b1;
    w_if_id_write_en  = 1'b1;
    w_if_id_flush     = 1'b0;
    w_id_ex_write_en  = 1'b1;
    w_id_ex_flush     = 1'b0;
    w_ex_mem_write_en = 1'b1;
    w_mem_wb_flush    = 1'b0;
    if (rst) begin
      // Hold every stage still while in reset.
      w_pc_write_en     = 1'b0;
      w_if_id_write_en  = 1'b0;
      w_id_ex_write_en  = 1'b0;
      w_ex_mem_write_en = 1'b0;
    end else if (w_mem_stall) begin
      // Freeze everything up to EX/MEM. Any pending branch or load-use
      // stays in place and is resolved once memory completes.
      w_pc_write_en     = 1'b0;
      w_if_id_write_en  = 1'b0;
      w_id_ex_write_en  = 1'b0;
      w_ex_mem_write_en = 1'b0;
      w_mem_wb_flush    = 1'b1;
    end else if (hz.ex_branch_taken) begin
      // The ID instruction is on the wrong path, so its load-use is moot.
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      // One bubble; forwarding covers the dependency after that.
      w_pc_write_en    = 1'b0;
      w_if_id_write_en = 1'b0;
      w_id_ex_flush    = 1'b1;
    end
  end

  // Watchdog: count consecutive memory-stall cycles, latch a sticky error
  // on the MEM_TIMEOUT-th one. The error never alters pipeline control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt        <= '0;
      r_mem_timeout_err <= 1'b0;
    end else begin
      if (!w_mem_stall) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != '1) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_mem_stall && (r_wait_cnt == WAIT_LAST)) begin
        r_mem_timeout_err <= 1'b1;
      end
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (!w_pc_write_en && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if (w_if_id_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign hz.pc_write_en     = w_pc_write_en;
  assign hz.if_id_write_en  = w_if_id_write_en;
  assign hz.if_id_flush     = w_if_id_flush;
  assign hz.id_ex_write_en  = w_id_ex_write_en;
  assign hz.id_ex_flush     = w_id_ex_flush;
  assign hz.ex_mem_write_en = w_ex_mem_write_en;
  assign hz.mem_wb_flush    = w_mem_wb_flush;
  assign hz.mem_timeout_err = r_mem_timeout_err;
  assign hz.stall_count     = r_stall_count;
  assign hz.flush_count     = r_flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit with MEM_TIMEOUT=4, CNT_W=4.
// A behavioural model predicts controls, counters and watchdog every cycle;
// directed steps add literal expectations at the interesting points.
module tb_hazard_control_unit;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   cmp_on;

  hazard_control_unit_if #(.CNT_W(CNT_W)) hz();

  hazard_control_unit #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control response: one of four pipeline reactions.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_fl;
    logic idex_we;
    logic idex_fl;
    logic exmem_we;
    logic memwb_fl;
  } ctrl_t;

  function automatic ctrl_t expect_ctrl();
    ctrl_t c;
    bit    stall_mem;
    bit    dep;
    stall_mem = hz.mem_req && !hz.mem_ready;
    dep = hz.id_ex_mem_read_en && (hz.id_ex_rd_addr != 0) &&
          ((hz.if_id_rs1_used && hz.id_ex_rd_addr == hz.if_id_rs1_addr) ||
           (hz.if_id_rs2_used && hz.id_ex_rd_addr == hz.if_id_rs2_addr));
    if (rst)                     c = 7'b0000000;
    else if (stall_mem)          c = 7'b0000001; // frozen, MEM/WB bubble
    else if (hz.ex_branch_taken) c = 7'b1111110; // squash IF/ID and ID/EX
    else if (dep)                c = 7'b0001110; // hold PC/IF-ID, ID/EX bubble
    else                         c = 7'b1101010; // normal flow
    return c;
  endfunction

  ctrl_t m_ctrl;
  always_comb m_ctrl = expect_ctrl();

  // Model state: run length of consecutive memory stalls and event totals.
  int m_run;
  int m_stall;
  int m_flush;
  bit m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run   <= 0;
      m_stall <= 0;
      m_flush <= 0;
      m_err   <= 1'b0;
    end else begin
      if (hz.mem_req && !hz.mem_ready) begin
        m_run <= m_run + 1;
        if (m_run + 1 >= MEM_TIMEOUT) m_err <= 1'b1;
      end else begin
        m_run <= 0;
      end
      if (!m_ctrl.pc_we)  m_stall <= (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (m_ctrl.ifid_fl) m_flush <= (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("pc_write_en",     int'(hz.pc_write_en),     int'(m_ctrl.pc_we));
      chk("if_id_write_en",  int'(hz.if_id_write_en),  int'(m_ctrl.ifid_we));
      chk("if_id_flush",     int'(hz.if_id_flush),     int'(m_ctrl.ifid_fl));
      chk("id_ex_write_en",  int'(hz.id_ex_write_en),  int'(m_ctrl.idex_we));
      chk("id_ex_flush",     int'(hz.id_ex_flush),     int'(m_ctrl.idex_fl));
      chk("ex_mem_write_en", int'(hz.ex_mem_write_en), int'(m_ctrl.exmem_we));
      chk("mem_wb_flush",    int'(hz.mem_wb_flush),    int'(m_ctrl.memwb_fl));
      chk("mem_timeout_err", int'(hz.mem_timeout_err), int'(m_err));
      chk("stall_count",     int'(hz.stall_count),     m_stall);
      chk("flush_count",     int'(hz.flush_count),     m_flush);
    end
  end

  task automatic clr();
    hz.if_id_rs1_addr    = 5'd0;
    hz.if_id_rs2_addr    = 5'd0;
    hz.if_id_rs1_used    = 1'b0;
    hz.if_id_rs2_used    = 1'b0;
    hz.id_ex_rd_addr     = 5'd0;
    hz.id_ex_mem_read_en = 1'b0;
    hz.ex_branch_taken   = 1'b0;
    hz.mem_req           = 1'b0;
    hz.mem_ready         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    $display("step t=%0t pc_we=%0b ifid_fl=%0b stall=%0d flush=%0d err=%0b",
             $time, hz.pc_write_en, hz.if_id_flush, hz.stall_count,
             hz.flush_count, hz.mem_timeout_err);
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    hz.id_ex_mem_read_en = 1'b1;
    hz.id_ex_rd_addr     = rd;
    hz.if_id_rs1_addr    = rs1;
    hz.if_id_rs1_used    = u1;
    hz.if_id_rs2_addr    = rs2;
    hz.if_id_rs2_used    = u2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_on = 1'b1;
    rst    = 1'b1;
    clr();
    #3;
    chk("rst_pc_we",  int'(hz.pc_write_en),  0);
    chk("rst_stall",  int'(hz.stall_count),  0);
    chk("rst_flush",  int'(hz.flush_count),  0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle cycle: normal flow.
    step();
    chk("idle_stall", int'(hz.stall_count), 0);

    // Load-use on rs1: one stall.
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk("lu_pc_we",   int'(hz.pc_write_en),    0);
    chk("lu_ifid_we", int'(hz.if_id_write_en), 0);
    chk("lu_idex_fl", int'(hz.id_ex_flush),    1);
    step();
    chk("lu_stall_cnt", int'(hz.stall_count), 1);

    // Load to x0 with matching rs1=x0: no stall.
    clr();
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    #1 chk("x0_pc_we", int'(hz.pc_write_en), 1);
    step();

    // rs2 matches but is not used: no stall.
    clr();
    set_lu(5'd7, 5'd0, 1'b0, 5'd7, 1'b0);
    #1 chk("unused_pc_we", int'(hz.pc_write_en), 1);
    step();
    chk("unused_stall_cnt", int'(hz.stall_count), 1);

    // Branch plus load-use: branch wins, no stall counted.
    clr();
    set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    hz.ex_branch_taken = 1'b1;
    #1;
    chk("br_lu_pc_we",   int'(hz.pc_write_en), 1);
    chk("br_lu_ifid_fl", int'(hz.if_id_flush), 1);
    chk("br_lu_idex_fl", int'(hz.id_ex_flush), 1);
    step();
    chk("br_lu_flush_cnt", int'(hz.flush_count), 1);
    chk("br_lu_stall_cnt", int'(hz.stall_count), 1);

    // Memory wait of 3 cycles with a branch held behind it.
    clr();
    hz.ex_branch_taken = 1'b1;
    hz.mem_req         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_pc_we",    int'(hz.pc_write_en),     0);
      chk("mw_exmem_we", int'(hz.ex_mem_write_en), 0);
      chk("mw_memwb_fl", int'(hz.mem_wb_flush),    1);
      chk("mw_ifid_fl",  int'(hz.if_id_flush),     0);
      step();
    end
    chk("mw_stall_cnt", int'(hz.stall_count), 4);
    hz.mem_ready = 1'b1;
    #1;
    chk("mr_ifid_fl", int'(hz.if_id_flush),  1);
    chk("mr_pc_we",   int'(hz.pc_write_en),  1);
    step();
    chk("mr_flush_cnt", int'(hz.flush_count),     2);
    chk("mr_no_err",    int'(hz.mem_timeout_err), 0);

    // Four consecutive stall cycles trip the watchdog.
    clr();
    step();
    hz.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("wd_3_no_err", int'(hz.mem_timeout_err), 0);
    step();
    chk("wd_4_err", int'(hz.mem_timeout_err), 1);
    clr();
    step();
    step();
    chk("wd_sticky", int'(hz.mem_timeout_err), 1);

    // Long stall saturates the stall counter.
    hz.mem_req = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_cnt", int'(hz.stall_count), CNT_MAX);

    // Asynchronous reset mid-stall.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_stall",  int'(hz.stall_count),     0);
    chk("arst_flush",  int'(hz.flush_count),     0);
    chk("arst_err",    int'(hz.mem_timeout_err), 0);
    chk("arst_pc_we",  int'(hz.pc_write_en),     0);
    chk("arst_memwb",  int'(hz.mem_wb_flush),    0);
    @(posedge clk);
    #1 rst = 1'b0;

    // New stall after reset counts from zero.
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_err",   int'(hz.mem_timeout_err), 0);
    chk("post_rst_stall", int'(hz.stall_count),     3);
    hz.mem_ready = 1'b1;
    step();
    clr();
    step();

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
